// File: rtl/miner_pkg.sv
// Shared definitions for the nonce sweep sequencer.
// Contents: FSM state encoding, host register map addresses, header/target word counts.
// Imported by nonce_sweep_ctrl.
package miner_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int HDR_WORDS    = 20;
  localparam int TARGET_WORDS = 8;

  // Host register map (word addresses); 0..18 are header words.
  localparam logic [4:0] ADDR_NONCE_START = 5'd19;
  localparam logic [4:0] ADDR_NONCE_END   = 5'd20;
  localparam logic [4:0] ADDR_TARGET0     = 5'd21;
  localparam logic [4:0] ADDR_CTRL        = 5'd29;

endpackage

// File: rtl/hash_target_cmp.sv
// Registered 256-bit unsigned compare: lt <= (hash < target), one cycle of latency.
// Ports: clk, rst (async, active-high), hash/target in, lt out.
// Free-running; the caller decides which cycle's result it consumes.
module hash_target_cmp (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] hash,
  input  logic [255:0] target,
  output logic         lt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt <= 1'b0;
    end else begin
      lt <= (hash < target);
    end
  end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep sequencer: holds header/target/range, launches the miner core once
// per nonce, reports first winning nonce, range exhaustion or core timeout.
// Ports: host write strobe/addr/data; core start/header/done/hash; status flags, nonces, irq.
module nonce_sweep_ctrl #(
  parameter int BITS      = 32,
  parameter int HDR_WORDS = 20,
  parameter int TIMEOUT   = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [4:0]                wr_addr,
  input  logic [BITS-1:0]           wr_data,
  output logic                      core_start,
  output logic [BITS*HDR_WORDS-1:0] core_header,
  input  logic                      core_done,
  input  logic [255:0]              core_hash,
  output logic                      busy,
  output logic                      found,
  output logic                      exhausted,
  output logic                      timeout_err,
  output logic [BITS-1:0]           found_nonce,
  output logic [BITS-1:0]           cur_nonce,
  output logic                      irq
);

  import miner_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [BITS-1:0] hdr_q [HDR_WORDS-1];
  logic [BITS-1:0] nonce_start_q;
  logic [BITS-1:0] nonce_end_q;
  logic [255:0]    target_q;

  state_t          state, state_d;
  logic            done_q;
  logic [WD_W-1:0] wdog;
  logic            hash_lt;

  logic start_cmd, abort_cmd, done_rise;
  logic load_start, clr_wdog, inc_nonce, set_found, set_exh, set_to;

  assign start_cmd = wr_en && (wr_addr == ADDR_CTRL) && wr_data[0];
  assign abort_cmd = wr_en && (wr_addr == ADDR_CTRL) && wr_data[1];
  assign done_rise = core_done && !done_q;

  // Header words plus the live nonce in the top slot.
  for (genvar k = 0; k < HDR_WORDS - 1; k++) begin : g_hdr
    assign core_header[BITS*k +: BITS] = hdr_q[k];
  end
  assign core_header[BITS*(HDR_WORDS-1) +: BITS] = cur_nonce;

  // Result is registered on the same edge that detects core_done rising,
  // so it is valid exactly in CHECK.
  hash_target_cmp u_cmp (
    .clk    (clk),
    .rst    (rst),
    .hash   (core_hash),
    .target (target_q),
    .lt     (hash_lt)
  );

  // Host-visible configuration; frozen while a sweep is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < HDR_WORDS - 1; k++) hdr_q[k] <= '0;
      nonce_start_q <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
    end else if (wr_en && !busy) begin
      for (int k = 0; k < HDR_WORDS - 1; k++) begin
        if (wr_addr == 5'(k)) hdr_q[k] <= wr_data;
      end
      if (wr_addr == ADDR_NONCE_START) nonce_start_q <= wr_data;
      if (wr_addr == ADDR_NONCE_END)   nonce_end_q   <= wr_data;
      for (int t = 0; t < TARGET_WORDS; t++) begin
        if (wr_addr == ADDR_TARGET0 + 5'(t)) target_q[BITS*t +: BITS] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Abort has priority over every in-flight event, including a result arriving.
  always_comb begin
    state_d    = state;
    load_start = 1'b0;
    clr_wdog   = 1'b0;
    inc_nonce  = 1'b0;
    set_found  = 1'b0;
    set_exh    = 1'b0;
    set_to     = 1'b0;
    core_start = 1'b0;
    irq        = 1'b0;
    busy       = (state != S_IDLE) && (state != S_DONE);
    case (state)
      S_IDLE: begin
        if (start_cmd && !abort_cmd) begin
          load_start = 1'b1;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        clr_wdog   = 1'b1;
        state_d    = abort_cmd ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (done_rise) begin
          state_d = S_CHECK;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          set_to  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CHECK: begin
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (hash_lt) begin
          set_found = 1'b1;
          state_d   = S_DONE;
        end else if (cur_nonce == nonce_end_q) begin
          set_exh = 1'b1;
          state_d = S_DONE;
        end else begin
          inc_nonce = 1'b1;
          state_d   = S_LAUNCH;
        end
      end
      S_DONE: begin
        irq     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_nonce   <= '0;
      found_nonce <= '0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= core_done;
      if (load_start) begin
        cur_nonce   <= nonce_start_q;
        found       <= 1'b0;
        exhausted   <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (inc_nonce) cur_nonce <= cur_nonce + 1'b1;
      if (set_found) begin
        found       <= 1'b1;
        found_nonce <= cur_nonce;
      end
      if (set_exh) exhausted   <= 1'b1;
      if (set_to)  timeout_err <= 1'b1;
      if (clr_wdog)            wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 1'b1;
    end
  end

endmodule
